// File: rtl/uart_core_if.sv
// uart_core_if: TX request / RX delivery bundle plus serial lines.
// master drives requests and rx line; slave is the UART core.
interface uart_core_if #(
  parameter int DATA_BITS = 8
);
  logic                 tx_start;
  logic [DATA_BITS-1:0] tx_data_in;
  logic                 tx_busy;
  logic                 uart_tx_out;
  logic                 uart_rx_in;
  logic [DATA_BITS-1:0] rx_data_out;
  logic                 rx_data_valid;
  logic                 rx_parity_err;
  logic                 rx_frame_err;

  modport master (
    output tx_start, tx_data_in, uart_rx_in,
    input  tx_busy, uart_tx_out, rx_data_out,
    input  rx_data_valid, rx_parity_err, rx_frame_err
  );

  modport slave (
    input  tx_start, tx_data_in, uart_rx_in,
    output tx_busy, uart_tx_out, rx_data_out,
    output rx_data_valid, rx_parity_err, rx_frame_err
  );
endinterface

// File: rtl/uart_core.sv
// uart_core: independent UART TX and oversampled RX, fixed frame format.
// Optional UART_CORE_LOOPBACK_EN adds a loopback port (TX fed into RX).
module uart_core #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic      clk,
  input  logic      rst,
`ifdef UART_CORE_LOOPBACK_EN
  input  logic      loopback,
`endif
  uart_core_if.slave bus
);

  localparam int OSB    = BAUD * OVERSAMPLE;
  localparam int DIV    = (CLK_HZ + OSB / 2) / OSB;
  localparam int BIT_CK = DIV * OVERSAMPLE;
  localparam int PAR_N  = (PARITY != 0) ? 1 : 0;
  localparam int FRAME  = 1 + DATA_BITS + PAR_N + STOP_BITS;
  localparam int BCW    = $clog2(BIT_CK + 1);
  localparam int FCW    = $clog2(FRAME + 1);
  localparam int DCW    = $clog2(DIV + 1);
  localparam int TCW    = $clog2(OVERSAMPLE + 1);
  localparam int NBW    = $clog2(DATA_BITS + 1);

  // ---------------- TX ----------------
  logic [FRAME-1:0] tx_frame;
  logic [FRAME-1:0] tx_shift_q, tx_shift_d;
  logic [BCW-1:0]   tx_cnt_q, tx_cnt_d;
  logic [FCW-1:0]   tx_bit_q, tx_bit_d;
  logic             tx_busy_q, tx_busy_d;
  logic             rx_src;

  always_comb begin
    tx_frame = '1;
    tx_frame[0] = 1'b0;
    tx_frame[DATA_BITS:1] = bus.tx_data_in;
    if (PARITY == 1) tx_frame[DATA_BITS+1] = ^bus.tx_data_in;
    else if (PARITY == 2) tx_frame[DATA_BITS+1] = ~^bus.tx_data_in;
  end

  // Line is always shift[0]; the register refills with ones as it drains.
  always_comb begin
    tx_shift_d = tx_shift_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_busy_d  = tx_busy_q;
    if (!tx_busy_q) begin
      if (bus.tx_start) begin
        tx_shift_d = tx_frame;
        tx_cnt_d   = '0;
        tx_bit_d   = '0;
        tx_busy_d  = 1'b1;
      end
    end else if (tx_cnt_q == BCW'(BIT_CK - 1)) begin
      tx_cnt_d   = '0;
      tx_shift_d = {1'b1, tx_shift_q[FRAME-1:1]};
      if (tx_bit_q == FCW'(FRAME - 1)) tx_busy_d = 1'b0;
      else tx_bit_d = tx_bit_q + 1'b1;
    end else begin
      tx_cnt_d = tx_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_shift_q <= '1;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_busy_q  <= 1'b0;
    end else begin
      tx_shift_q <= tx_shift_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_busy_q  <= tx_busy_d;
    end
  end

  assign bus.tx_busy = tx_busy_q;

`ifdef UART_CORE_LOOPBACK_EN
  assign bus.uart_tx_out = loopback | tx_shift_q[0];
  assign rx_src = loopback ? tx_shift_q[0] : bus.uart_rx_in;
`else
  assign bus.uart_tx_out = tx_shift_q[0];
  assign rx_src = bus.uart_rx_in;
`endif

  // ---------------- RX ----------------
  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP
  } rx_state_e;

  rx_state_e            rx_state_q, rx_state_d;
  logic                 rx_meta_q, rx_sync_q, rx_prev_q;
  logic [DCW-1:0]       rx_div_q, rx_div_d;
  logic [TCW-1:0]       rx_tck_q, rx_tck_d;
  logic [NBW-1:0]       rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 rx_par_q, rx_par_d;
  logic [DATA_BITS-1:0] rx_dout_q, rx_dout_d;
  logic                 rx_vld_q, rx_vld_d;
  logic                 rx_perr_q, rx_perr_d;
  logic                 rx_ferr_q, rx_ferr_d;
  logic                 rx_fall, rx_tick, rx_samp, rx_exp_par;
  logic [TCW-1:0]       rx_lim;

  assign rx_fall = rx_prev_q & ~rx_sync_q;
  assign rx_tick = (rx_div_q == DCW'(DIV - 1));
  assign rx_lim  = (rx_state_q == RX_START) ?
                   TCW'(OVERSAMPLE / 2 - 1) : TCW'(OVERSAMPLE - 1);
  assign rx_samp = rx_tick & (rx_tck_q == rx_lim);
  assign rx_exp_par = (PARITY == 2) ? ~^rx_shift_q : ^rx_shift_q;

  always_ff @(posedge clk) begin
    if (rst) rx_state_q <= RX_IDLE;
    else rx_state_q <= rx_state_d;
  end

  always_comb begin
    rx_state_d = rx_state_q;
    unique case (rx_state_q)
      RX_IDLE:  if (rx_fall) rx_state_d = RX_START;
      RX_START: if (rx_samp) rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
      RX_DATA:
        if (rx_samp && rx_bit_q == NBW'(DATA_BITS - 1))
          rx_state_d = (PARITY != 0) ? RX_PAR : RX_STOP;
      RX_PAR:   if (rx_samp) rx_state_d = RX_STOP;
      RX_STOP:  if (rx_samp) rx_state_d = RX_IDLE;
      default:  rx_state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    rx_div_d   = '0;
    rx_tck_d   = '0;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_par_d   = rx_par_q;
    rx_dout_d  = rx_dout_q;
    rx_vld_d   = 1'b0;
    rx_perr_d  = 1'b0;
    rx_ferr_d  = 1'b0;
    if (rx_state_q == RX_IDLE) begin
      rx_bit_d = '0;
    end else begin
      rx_div_d = rx_tick ? '0 : rx_div_q + 1'b1;
      rx_tck_d = rx_samp ? '0 : (rx_tick ? rx_tck_q + 1'b1 : rx_tck_q);
    end
    if (rx_samp) begin
      unique case (rx_state_q)
        RX_DATA: begin
          rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
          rx_bit_d   = rx_bit_q + 1'b1;
        end
        RX_PAR: rx_par_d = rx_sync_q;
        RX_STOP: begin
          rx_dout_d = rx_shift_q;
          rx_vld_d  = 1'b1;
          rx_ferr_d = ~rx_sync_q;
          rx_perr_d = (PARITY != 0) && (rx_par_q != rx_exp_par);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_div_q   <= '0;
      rx_tck_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_par_q   <= 1'b0;
      rx_dout_q  <= '0;
      rx_vld_q   <= 1'b0;
      rx_perr_q  <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rx_meta_q  <= rx_src;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      rx_div_q   <= rx_div_d;
      rx_tck_q   <= rx_tck_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_par_q   <= rx_par_d;
      rx_dout_q  <= rx_dout_d;
      rx_vld_q   <= rx_vld_d;
      rx_perr_q  <= rx_perr_d;
      rx_ferr_q  <= rx_ferr_d;
    end
  end

  assign bus.rx_data_out   = rx_dout_q;
  assign bus.rx_data_valid = rx_vld_q;
  assign bus.rx_parity_err = rx_perr_q;
  assign bus.rx_frame_err  = rx_ferr_q;

endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core: directed checks of uart_core (8N1 instance and 8E1 instance).
// Bit period is 432 clks at the default clock and baud.
module tb_uart_core;
  localparam int BP = 432;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_core_if #(.DATA_BITS(8)) bus_a ();
  uart_core_if #(.DATA_BITS(8)) bus_b ();

  uart_core u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  uart_core #(.PARITY(1)) u_par (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int cnt_a = 0;
  int cnt_b = 0;
  logic [7:0] dat_a, dat_b;
  logic pe_a, fe_a, pe_b, fe_b;

  always @(negedge clk) begin
    if (bus_a.rx_data_valid === 1'b1) begin
      cnt_a++;
      dat_a = bus_a.rx_data_out;
      pe_a = bus_a.rx_parity_err;
      fe_a = bus_a.rx_frame_err;
    end
    if (bus_b.rx_data_valid === 1'b1) begin
      cnt_b++;
      dat_b = bus_b.rx_data_out;
      pe_b = bus_b.rx_parity_err;
      fe_b = bus_b.rx_frame_err;
    end
  end

  task automatic drive_frame(input int which, input logic [15:0] bits,
                             input int n);
    for (int i = 0; i < n; i++) begin
      if (which == 0) bus_a.uart_rx_in = bits[i];
      else bus_b.uart_rx_in = bits[i];
      repeat (BP) @(negedge clk);
    end
  endtask

  logic hist [0:8700];
  logic [9:0] fb_first, fb_last, fb_exp;
  logic [7:0] f1, f2;
  logic [15:0] fr;
  int busy_cnt, s2, base;

  initial begin
    rst = 1'b1;
    bus_a.tx_start = 1'b0;
    bus_a.tx_data_in = '0;
    bus_a.uart_rx_in = 1'b1;
    bus_b.tx_start = 1'b0;
    bus_b.tx_data_in = '0;
    bus_b.uart_rx_in = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_tx_line", bus_a.uart_tx_out, 1);
    check("rst_tx_busy", bus_a.tx_busy, 0);
    check("rst_rx_data", bus_a.rx_data_out, 0);
    check("rst_rx_valid", bus_a.rx_data_valid, 0);
    check("rst_perr", bus_a.rx_parity_err, 0);
    check("rst_ferr", bus_a.rx_frame_err, 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // TX 8N1 timing with 0xA5
    bus_a.tx_start = 1'b1;
    bus_a.tx_data_in = 8'hA5;
    busy_cnt = 0;
    fb_exp = {1'b1, 8'hA5, 1'b0};
    for (int j = 1; j <= 4330; j++) begin
      @(negedge clk);
      if (j == 1) bus_a.tx_start = 1'b0;
      if (bus_a.tx_busy === 1'b1) busy_cnt++;
      if (j <= 4320) begin
        if ((j - 1) % BP == 0) fb_first[(j - 1) / BP] = bus_a.uart_tx_out;
        if ((j - 1) % BP == BP - 1) fb_last[(j - 1) / BP] = bus_a.uart_tx_out;
      end
    end
    check("tx_bits_head", fb_first, fb_exp);
    check("tx_bits_tail", fb_last, fb_exp);
    check("tx_busy_len", busy_cnt, 4320);
    check("tx_idle_after", bus_a.uart_tx_out, 1);

    // back-to-back TX, start held high
    bus_a.tx_start = 1'b1;
    bus_a.tx_data_in = 8'h01;
    s2 = 0;
    for (int j = 1; j <= 8700; j++) begin
      @(negedge clk);
      hist[j] = bus_a.uart_tx_out;
      if (j == 1) bus_a.tx_data_in = 8'h02;
      if (s2 == 0 && j > 4320 && bus_a.uart_tx_out == 1'b0) begin
        s2 = j;
        bus_a.tx_data_in = 8'h03;
        bus_a.tx_start = 1'b0;
      end
    end
    for (int k = 1; k <= 8; k++) begin
      f1[k-1] = hist[1 + BP * k + BP / 2];
      f2[k-1] = hist[s2 + BP * k + BP / 2];
    end
    check("b2b_second_start", s2, 4322);
    check("b2b_frame1", f1, 8'h01);
    check("b2b_frame1_stop", hist[1 + BP * 9 + BP / 2], 1);
    check("b2b_frame2_start", hist[s2 + BP / 2], 0);
    check("b2b_frame2", f2, 8'h02);
    check("b2b_idle", bus_a.tx_busy, 0);

    // RX even parity, good then flipped parity bit
    fr = {5'b0, 1'b1, 1'b0, 8'h3C, 1'b0};
    drive_frame(1, fr, 11);
    repeat (200) @(negedge clk);
    check("par_ok_cnt", cnt_b, 1);
    check("par_ok_data", dat_b, 8'h3C);
    check("par_ok_perr", pe_b, 0);
    check("par_ok_ferr", fe_b, 0);
    fr = {5'b0, 1'b1, 1'b1, 8'h3C, 1'b0};
    drive_frame(1, fr, 11);
    repeat (200) @(negedge clk);
    check("par_bad_cnt", cnt_b, 2);
    check("par_bad_data", dat_b, 8'h3C);
    check("par_bad_perr", pe_b, 1);
    check("par_bad_ferr", fe_b, 0);

    // framing error: stop forced low, line held low afterwards
    base = cnt_a;
    fr = {6'b0, 1'b0, 8'h55, 1'b0};
    drive_frame(0, fr, 10);
    check("ferr_cnt", cnt_a, base + 1);
    check("ferr_data", dat_a, 8'h55);
    check("ferr_flag", fe_a, 1);
    check("ferr_perr", pe_a, 0);
    repeat (3000) @(negedge clk);
    check("ferr_no_refire", cnt_a, base + 1);
    bus_a.uart_rx_in = 1'b1;
    repeat (500) @(negedge clk);

    // false start: 100-clk low glitch, then a good frame
    base = cnt_a;
    bus_a.uart_rx_in = 1'b0;
    repeat (100) @(negedge clk);
    bus_a.uart_rx_in = 1'b1;
    repeat (1000) @(negedge clk);
    check("glitch_no_valid", cnt_a, base);
    fr = {6'b0, 1'b1, 8'h81, 1'b0};
    drive_frame(0, fr, 10);
    repeat (200) @(negedge clk);
    check("after_glitch_cnt", cnt_a, base + 1);
    check("after_glitch_data", dat_a, 8'h81);
    check("after_glitch_ferr", fe_a, 0);

    // reset at bit 4 of both an RX and a TX frame
    base = cnt_a;
    fr = {6'b0, 1'b1, 8'hFF, 1'b0};
    bus_a.tx_start = 1'b1;
    bus_a.tx_data_in = 8'h00;
    for (int k = 0; k < 4; k++) begin
      bus_a.uart_rx_in = fr[k];
      repeat (BP) @(negedge clk);
      bus_a.tx_start = 1'b0;
    end
    bus_a.uart_rx_in = fr[4];
    repeat (BP / 2) @(negedge clk);
    check("mid_tx_busy", bus_a.tx_busy, 1);
    rst = 1'b1;
    bus_a.uart_rx_in = 1'b1;
    repeat (3) @(negedge clk);
    check("mrst_line", bus_a.uart_tx_out, 1);
    check("mrst_busy", bus_a.tx_busy, 0);
    check("mrst_valid", bus_a.rx_data_valid, 0);
    rst = 1'b0;
    repeat (5000) @(negedge clk);
    check("mrst_no_valid", cnt_a, base);
    check("mrst_line_idle", bus_a.uart_tx_out, 1);
    check("mrst_busy_idle", bus_a.tx_busy, 0);
    fr = {6'b0, 1'b1, 8'hF0, 1'b0};
    drive_frame(0, fr, 10);
    repeat (200) @(negedge clk);
    check("post_rst_cnt", cnt_a, base + 1);
    check("post_rst_data", dat_a, 8'hF0);
    check("post_rst_ferr", fe_a, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_core.md
UART_CORE -- requirements
Module: uart_core

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, line rate in bit/s.
REQ-003 SHALL have parameter OVERSAMPLE, default 16, RX sample ticks per bit; legal values are even and 8..32.
REQ-004 SHALL have parameter DATA_BITS, default 8, payload width; legal range 5..9.
REQ-005 SHALL have parameter PARITY, default 0; 0 means none, 1 means even, 2 means odd.
REQ-006 SHALL have parameter STOP_BITS, default 1; legal values 1 or 2.
REQ-007 SHALL have port clk, input, 1 bit, the single clock; all logic is clocked on its rising edge.
REQ-008 SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-009 SHALL have port tx_start, input, 1 bit, transmit request, sampled every clk.
REQ-010 SHALL have port tx_data_in, input, DATA_BITS wide, byte to send, captured on acceptance.
REQ-011 SHALL have port tx_busy, output, 1 bit, high while a frame is in flight.
REQ-012 SHALL have port uart_tx_out, output, 1 bit, serial line, idle high.
REQ-013 SHALL have port uart_rx_in, input, 1 bit, asynchronous serial line.
REQ-014 SHALL have port rx_data_out, output, DATA_BITS wide, last received payload.
REQ-015 SHALL have port rx_data_valid, output, 1 bit, one-clk pulse per completed frame.
REQ-016 SHALL have port rx_parity_err, output, 1 bit, qualifies rx_data_valid.
REQ-017 SHALL have port rx_frame_err, output, 1 bit, qualifies rx_data_valid.

Function
REQ-018 SHALL derive DIV = round(CLK_HZ/(BAUD*OVERSAMPLE)) at elaboration; the bit period is DIV*OVERSAMPLE clks for both TX and RX.
REQ-019 SHALL accept a TX request when tx_start=1 and tx_busy=0: capture tx_data_in, assert tx_busy the next clk, drive the start bit (0) from the same clk, and restart the TX bit timer.
REQ-020 SHALL ignore tx_start while tx_busy=1; the captured data is not altered.
REQ-021 SHALL transmit the TX frame as: start, DATA_BITS LSB first, the parity bit if PARITY≠0, then STOP_BITS high bits, with each bit lasting exactly one bit period.
REQ-022 SHALL deassert tx_busy on the clk after the last stop bit ends; a tx_start on that clk is accepted, giving back-to-back frames with no idle gap.
REQ-023 SHALL pass uart_rx_in through a 2-flop synchronizer before any use.
REQ-024 SHALL implement the RX FSM with states IDLE, START, DATA, PAR, STOP.
- IDLE to START on a synchronized 1-to-0 edge.
- START: check the line at OVERSAMPLE/2 ticks; if it is 1 (false start), return to IDLE with no output; otherwise go to DATA.
- DATA: sample each bit every OVERSAMPLE ticks after the start-bit centre, LSB first.
- PAR: entered only if PARITY≠0.
- STOP: sample the first stop bit only, then return to IDLE.
REQ-025 SHALL, at the STOP sample: update rx_data_out, pulse rx_data_valid for 1 clk, and assert rx_parity_err on parity mismatch and rx_frame_err if the stop sample is 0, both on the same clk.
REQ-026 SHALL deliver the payload even when an error flag is set.
REQ-027 SHALL hold rx_data_out until the next valid pulse.
REQ-028 SHALL, when the stop sample is 0 (break or framing error), return RX to IDLE and require the line to read 1 before a new start is detected.
REQ-029 SHALL run TX and RX fully independently; simultaneous TX and RX activity SHALL NOT interact.

Reset
REQ-030 SHALL, while rst=1, force uart_tx_out=1, tx_busy=0, rx_data_out=0, rx_data_valid=0, rx_parity_err=0, rx_frame_err=0, synchronizer flops=1, all counters=0, and the RX FSM to IDLE.
REQ-031 SHALL, on reset mid-frame, abort the frame immediately with no valid pulse; the first frame after reset starts cleanly.

Configuration
REQ-032 SHALL support macro UART_CORE_LOOPBACK_EN: when defined, add input port loopback (1 bit); when loopback=1, the RX synchronizer input is uart_tx_out and uart_tx_out is held at 1. When the macro is undefined, there is no port and RX always uses uart_rx_in.

Verification (CLK_HZ=50000000, BAUD=115200, OVERSAMPLE=16, so DIV=27 and a bit is 432 clks)
REQ-033 SHALL verify TX 8N1 timing: tx_start with 0xA5 gives a 0 bit, then 1,0,1,0,0,1,0,1, then a 1 bit, each 432 clks; tx_busy stays high for 4320 clks.
REQ-034 SHALL verify RX with PARITY=1: drive 0x3C with correct even parity, then drive it again with the parity bit flipped; expect 0x3C with a valid pulse each time, rx_parity_err=0 then 1.
REQ-035 SHALL verify framing: drive 0x55 with the stop bit forced to 0; expect valid=1 and rx_frame_err=1, and no new frame while the line is held low.
REQ-036 SHALL verify false start: a 100-clk low glitch on the idle line gives no rx_data_valid and RX returns to IDLE.
REQ-037 SHALL verify back-to-back TX: tx_start held high across two frames (0x01, 0x02) gives no idle gap, and the second frame's data is captured only at acceptance.
REQ-038 SHALL verify reset mid-frame: rst asserted at bit 4 of an RX frame and of a TX frame gives line=1, busy=0 and no valid pulse; the next frame of 0xF0 is received correctly.
